// File: rtl/lcd_write_arbiter_pkg.sv
// rtl/lcd_write_arbiter_pkg.sv - shared FSM encodings, LCD handshake timing and arbitration helper
package lcd_write_arbiter_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_HOLD       = 2'd2;
    localparam logic [1:0] ST_WAIT_READY = 2'd3;

    // The LCD controller needs this many cycles to drop its ready after a strobe.
    localparam int HOLD_CYCLES = 1;
    localparam int HOLD_CNT_W  = 2;

    // Round-robin pick between two requesters: on a tie, favour the one not granted last.
    function automatic logic rr_pick(input logic [1:0] nonempty, input logic last_grant);
        logic pick;
        if (nonempty == 2'b11) begin
            pick = ~last_grant;
        end else begin
            pick = nonempty[1];
        end
        return pick;
    endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// rtl/lcd_byte_fifo.sv - small byte FIFO buffering one requester of the LCD write arbiter
module lcd_byte_fifo
    import lcd_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is silently dropped.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - round-robin arbiter merging two byte streams onto one LCD write port
module lcd_write_arbiter
    import lcd_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iReq0_Valid,
    input  logic [7:0] iReq0_Data,
    output logic       oReq0_Full,
    input  logic       iReq1_Valid,
    input  logic [7:0] iReq1_Data,
    output logic       oReq1_Full,
    output logic       oWrite,
    output logic [7:0] oData,
    input  logic       iReady,
    output logic       oGrant,
    output logic       oBusy
);

    logic [1:0]            state_q, state_d;
    logic [7:0]            data_q, data_d;
    logic                  grant_q, grant_d;
    logic                  last_q, last_d;
    logic [HOLD_CNT_W-1:0] hold_q, hold_d;

    logic       pop0, pop1;
    logic [7:0] head0, head1;
    logic       empty0, empty1;
    logic       pick;

    lcd_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo0 (
        .clk       (Clock),
        .rst_n     (Reset),
        .push      (iReq0_Valid),
        .push_data (iReq0_Data),
        .pop       (pop0),
        .pop_data  (head0),
        .full      (oReq0_Full),
        .empty     (empty0)
    );

    lcd_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo1 (
        .clk       (Clock),
        .rst_n     (Reset),
        .push      (iReq1_Valid),
        .push_data (iReq1_Data),
        .pop       (pop1),
        .pop_data  (head1),
        .full      (oReq1_Full),
        .empty     (empty1)
    );

    assign pick   = rr_pick({~empty1, ~empty0}, last_q);
    assign oWrite = (state_q == ST_ISSUE) & iReady;
    assign oData  = data_q;
    assign oGrant = grant_q;
    assign oBusy  = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;
        pop0    = 1'b0;
        pop1    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty0 || !empty1) begin
                    grant_d = pick;
                    last_d  = pick;
                    pop0    = ~pick;
                    pop1    = pick;
                    data_d  = pick ? head1 : head0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (iReady) begin
                    hold_d  = HOLD_CNT_W'(HOLD_CYCLES - 1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Ready is not trusted here: the controller may still be reporting idle.
                if (hold_q == '0) begin
                    state_d = ST_WAIT_READY;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (iReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - scoreboard bench for the LCD write arbiter
module tb_lcd_write_arbiter;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iReq0_Valid = 1'b0;
    logic [7:0] iReq0_Data = 8'h00;
    logic       oReq0_Full;
    logic       iReq1_Valid = 1'b0;
    logic [7:0] iReq1_Data = 8'h00;
    logic       oReq1_Full;
    logic       oWrite;
    logic [7:0] oData;
    logic       iReady = 1'b0;
    logic       oGrant;
    logic       oBusy;

    lcd_write_arbiter #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iReq0_Valid (iReq0_Valid),
        .iReq0_Data  (iReq0_Data),
        .oReq0_Full  (oReq0_Full),
        .iReq1_Valid (iReq1_Valid),
        .iReq1_Data  (iReq1_Data),
        .oReq1_Full  (oReq1_Full),
        .oWrite      (oWrite),
        .oData       (oData),
        .iReady      (iReady),
        .oGrant      (oGrant),
        .oBusy       (oBusy)
    );

    always #5 Clock = ~Clock;

    int         checks_total  = 0;
    int         checks_passed = 0;
    int         cyc           = 0;
    int         write_cnt     = 0;
    logic       prev_w        = 1'b0;
    logic [8:0] exp_q[$];
    int         wr_cyc_q[$];

    always @(posedge Clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected {grant, data}.
    always @(negedge Clock) begin
        logic [8:0] e;
        if (oWrite === 1'b1) begin
            write_cnt++;
            wr_cyc_q.push_back(cyc);
            chk("write_not_back_to_back", {31'd0, prev_w}, 32'd0);
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("FAIL unexpected_write: got grant %0d data 0x%0h expected no write", oGrant, oData);
            end else begin
                e = exp_q.pop_front();
                chk("write_data", {24'd0, oData}, {24'd0, e[7:0]});
                chk("write_grant", {31'd0, oGrant}, {31'd0, e[8]});
            end
        end
        prev_w = oWrite;
    end

    task automatic do_reset();
        Reset       = 1'b0;
        iReq0_Valid = 1'b0;
        iReq1_Valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
    endtask

    task automatic push(input int req, input logic [7:0] d);
        if (req == 0) begin
            iReq0_Valid = 1'b1;
            iReq0_Data  = d;
        end else begin
            iReq1_Valid = 1'b1;
            iReq1_Data  = d;
        end
        @(posedge Clock);
        #1;
        iReq0_Valid = 1'b0;
        iReq1_Valid = 1'b0;
    endtask

    task automatic push_both(input logic [7:0] d0, input logic [7:0] d1);
        iReq0_Valid = 1'b1;
        iReq0_Data  = d0;
        iReq1_Valid = 1'b1;
        iReq1_Data  = d1;
        @(posedge Clock);
        #1;
        iReq0_Valid = 1'b0;
        iReq1_Valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || oBusy) && n < max) begin
            @(posedge Clock);
            #1;
            n++;
        end
        chk({name, "_drain_in_time"}, {31'd0, n < max}, 32'd1);
    endtask

    task automatic wait_write(input string name, input int max);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (oWrite !== 1'b1 && n < max);
        chk({name, "_write_in_time"}, {31'd0, oWrite === 1'b1}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0;
        int r;

        // Reset values, observed before any clock edge.
        Reset = 1'b0;
        #1;
        chk("rst_oWrite", {31'd0, oWrite}, 32'd0);
        chk("rst_oData", {24'd0, oData}, 32'h00);
        chk("rst_oGrant", {31'd0, oGrant}, 32'd0);
        chk("rst_oBusy", {31'd0, oBusy}, 32'd0);
        chk("rst_full0", {31'd0, oReq0_Full}, 32'd0);
        chk("rst_full1", {31'd0, oReq1_Full}, 32'd0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;

        // Single push: strobe lands on the 2nd cycle after the push edge.
        iReady = 1'b1;
        exp_q.push_back({1'b0, 8'h41});
        push(0, 8'h41);
        @(negedge Clock);
        chk("single_no_write_1st_cycle", {31'd0, oWrite}, 32'd0);
        @(negedge Clock);
        chk("single_write_2nd_cycle", {31'd0, oWrite}, 32'd1);
        wait_drain("single", 50);

        // Tie: requester 0 wins first, then strict alternation.
        do_reset();
        iReady = 1'b1;
        wr_cyc_q.delete();
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h21});
        push_both(8'h10, 8'h20);
        push_both(8'h11, 8'h21);
        wait_drain("tie", 60);
        chk("tie_write_count", wr_cyc_q.size(), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < wr_cyc_q.size()) chk("tie_spacing", wr_cyc_q[i] - wr_cyc_q[i-1], 32'd4);
        end

        // Full: park the FSM on a requester-0 byte so requester 1 fills up.
        do_reset();
        iReady = 1'b0;
        exp_q.push_back({1'b0, 8'h55});
        push(0, 8'h55);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({1'b1, 8'hA0 + 8'(i)});
            push(1, 8'hA0 + 8'(i));
            chk($sformatf("full1_after_push%0d", i + 1), {31'd0, oReq1_Full}, {31'd0, i >= 3});
        end
        iReady = 1'b1;
        wait_drain("full", 100);
        chk("full1_cleared", {31'd0, oReq1_Full}, 32'd0);
        w0 = write_cnt;
        repeat (10) @(posedge Clock);
        chk("full_dropped_byte_not_written", write_cnt, w0);

        // Back-pressure: ready low for 20 cycles after the first strobe.
        do_reset();
        iReady = 1'b1;
        exp_q.push_back({1'b0, 8'h61});
        exp_q.push_back({1'b0, 8'h62});
        push(0, 8'h61);
        push(0, 8'h62);
        wait_write("bp_first", 10);
        @(posedge Clock);
        #1 iReady = 1'b0;
        w0 = write_cnt;
        repeat (20) @(posedge Clock);
        chk("bp_no_write_while_low", write_cnt, w0);
        #1 iReady = 1'b1;
        r = cyc;
        wait_write("bp_second", 10);
        chk("bp_second_not_early", {31'd0, (cyc - r) >= 1}, 32'd1);
        wait_drain("bp", 50);

        // Reset while parked in WAIT_READY with three bytes still queued.
        do_reset();
        iReady = 1'b0;
        exp_q.push_back({1'b0, 8'h71});
        push(0, 8'h71);
        push(0, 8'h72);
        push(0, 8'h73);
        push(0, 8'h74);
        iReady = 1'b1;
        @(posedge Clock);
        #1 iReady = 1'b0;
        @(posedge Clock);
        #1;
        chk("midrst_busy_before", {31'd0, oBusy}, 32'd1);
        chk("midrst_data_before", {24'd0, oData}, 32'h71);
        Reset = 1'b0;
        #1;
        chk("midrst_oWrite", {31'd0, oWrite}, 32'd0);
        chk("midrst_oData", {24'd0, oData}, 32'h00);
        chk("midrst_oGrant", {31'd0, oGrant}, 32'd0);
        chk("midrst_oBusy", {31'd0, oBusy}, 32'd0);
        chk("midrst_full0", {31'd0, oReq0_Full}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        iReady = 1'b1;
        w0 = write_cnt;
        repeat (20) @(posedge Clock);
        chk("midrst_no_write_after_release", write_cnt, w0);
        #1;
        exp_q.push_back({1'b0, 8'h99});
        push(0, 8'h99);
        wait_drain("midrst_new", 50);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
